my_pulse_stretcher: RTL and testbench



---
 rtl/my_pulse_stretcher_pkg.sv | 13 +
 rtl/my_tick_gen.sv | 32 +++
 rtl/my_pulse_stretcher.sv | 149 ++++++++++++++
 tb/tb_my_pulse_stretcher.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/my_pulse_stretcher_pkg.sv
// Shared constants for the pulse stretcher: FSM state encoding and the
// default 1 ms tick divider for a 100 MHz basys_clock.
package my_pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam int DEFAULT_TICK_DIV = 99999;

endpackage

// File: rtl/my_tick_gen.sv
// Millisecond tick divider: one-cycle strobe every TICK_DIV+1 cycles,
// realigned to phase zero by a synchronous restart.
module my_tick_gen
    import my_pulse_stretcher_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic basys_clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV);

    logic [CNT_W-1:0] cnt_r;

    // divider counter, zeroed on restart so every state starts a fresh tick period
    always_ff @(posedge basys_clock or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (restart || (cnt_r == CNT_LAST)) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign tick = (cnt_r == CNT_LAST);

endmodule

// File: rtl/my_pulse_stretcher.sv
// Stretches single-cycle events into ON_TICKS-long pulses separated by
// OFF_TICKS gaps, queueing overlapping events in a saturating counter.
module my_pulse_stretcher
    import my_pulse_stretcher_pkg::*;
#(
    parameter int TICK_DIV    = DEFAULT_TICK_DIV,
    parameter int ON_TICKS    = 200,
    parameter int OFF_TICKS   = 100,
    parameter int MAX_PENDING = 7,
    parameter int PEND_W      = 3
) (
    input  logic              basys_clock,
    input  logic              reset,
    input  logic              trigger,
    output logic              pulse_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending_count,
    output logic              dropped
);

    localparam int DUR_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int DUR_W   = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;
    localparam logic [DUR_W-1:0]  ON_LAST   = DUR_W'(ON_TICKS - 1);
    localparam logic [DUR_W-1:0]  OFF_LAST  = DUR_W'(OFF_TICKS - 1);
    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(MAX_PENDING);
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

    state_t            state_r;
    state_t            state_next_s;
    logic [DUR_W-1:0]  dur_r;
    logic [DUR_W-1:0]  dur_last_s;
    logic [PEND_W-1:0] pend_r;
    logic [PEND_W-1:0] pend_next_s;
    logic              pulse_r;
    logic              busy_r;
    logic              dropped_r;
    logic              dropped_s;
    logic              tick_s;
    logic              expire_s;
    logic              deq_s;
    logic              take_s;
    logic              queue_s;
    logic              restart_s;

    my_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .basys_clock (basys_clock),
        .reset       (reset),
        .restart     (restart_s),
        .tick        (tick_s)
    );

    // next-state, queue bookkeeping and drop detection
    always_comb begin
        state_next_s = state_r;
        pend_next_s  = pend_r;
        dropped_s    = 1'b0;
        dur_last_s   = (state_r == ST_ON) ? ON_LAST : OFF_LAST;
        expire_s     = tick_s && (dur_r == dur_last_s) && (state_r != ST_IDLE);
        deq_s        = (state_r == ST_OFF) && expire_s && (pend_r != {PEND_W{1'b0}});
        // a trigger that starts a pulse directly never touches the queue
        take_s       = trigger && ((state_r == ST_IDLE) ||
                       ((state_r == ST_OFF) && expire_s && (pend_r == {PEND_W{1'b0}})));
        queue_s      = trigger && !take_s && (state_r != ST_IDLE);

        case (state_r)
            ST_IDLE: begin
                if (trigger) begin
                    state_next_s = ST_ON;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ON: begin
                if (expire_s) begin
                    state_next_s = ST_OFF;
                end else begin
                    state_next_s = ST_ON;
                end
            end
            ST_OFF: begin
                if (expire_s && (deq_s || take_s)) begin
                    state_next_s = ST_ON;
                end else if (expire_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_OFF;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        // a dequeue frees a slot, so a coincident trigger is never dropped
        if (deq_s && queue_s) begin
            pend_next_s = pend_r;
        end else if (deq_s) begin
            pend_next_s = pend_r - PEND_ONE;
        end else if (queue_s) begin
            if (pend_r < PEND_FULL) begin
                pend_next_s = pend_r + PEND_ONE;
            end else begin
                dropped_s = 1'b1;
            end
        end else begin
            pend_next_s = pend_r;
        end
    end

    assign restart_s = (state_next_s != state_r);

    // state, queue and registered outputs aligned to the same edge
    always_ff @(posedge basys_clock or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            pend_r    <= {PEND_W{1'b0}};
            pulse_r   <= 1'b0;
            busy_r    <= 1'b0;
            dropped_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            pend_r    <= pend_next_s;
            pulse_r   <= (state_next_s == ST_ON);
            busy_r    <= (state_next_s != ST_IDLE);
            dropped_r <= dropped_s;
        end
    end

    // duration counter counts ticks within the current state
    always_ff @(posedge basys_clock or posedge reset) begin
        if (reset) begin
            dur_r <= {DUR_W{1'b0}};
        end else if (restart_s) begin
            dur_r <= {DUR_W{1'b0}};
        end else if (tick_s && (state_r != ST_IDLE)) begin
            dur_r <= dur_r + {{(DUR_W-1){1'b0}}, 1'b1};
        end else begin
            dur_r <= dur_r;
        end
    end

    assign pulse_out     = pulse_r;
    assign busy          = busy_r;
    assign pending_count = pend_r;
    assign dropped       = dropped_r;

endmodule

// File: tb/tb_my_pulse_stretcher.sv
// Directed bench for my_pulse_stretcher with a short tick (ON = 8 cycles,
// OFF = 4 cycles, queue depth 3).
module tb_my_pulse_stretcher;

    logic       basys_clock;
    logic       reset;
    logic       trigger;
    logic       pulse_out;
    logic       busy;
    logic [1:0] pending_count;
    logic       dropped;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    my_pulse_stretcher #(
        .TICK_DIV    (3),
        .ON_TICKS    (2),
        .OFF_TICKS   (1),
        .MAX_PENDING (3),
        .PEND_W      (2)
    ) dut (
        .basys_clock   (basys_clock),
        .reset         (reset),
        .trigger       (trigger),
        .pulse_out     (pulse_out),
        .busy          (busy),
        .pending_count (pending_count),
        .dropped       (dropped)
    );

    initial basys_clock = 1'b0;
    always #5 basys_clock = ~basys_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (cycle %0d): observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge basys_clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        trigger = 1'b0;
        reset   = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        int rises;
        int drops;
        logic prev_p;

        // reset state
        trigger = 1'b0;
        reset   = 1'b1;
        #2;
        check("rst_pulse", pulse_out, 0);
        check("rst_busy", busy, 0);
        check("rst_pend", pending_count, 0);
        check("rst_drop", dropped, 0);

        // 1: single trigger at cycle 10
        do_reset();
        while (cyc < 25) begin
            if (cyc >= 10) begin
                check("t1_pulse", pulse_out, ((cyc >= 11) && (cyc <= 18)) ? 1 : 0);
                check("t1_busy", busy, ((cyc >= 11) && (cyc <= 22)) ? 1 : 0);
                check("t1_pend", pending_count, 0);
            end
            trigger = (cyc == 10);
            next_cycle();
        end

        // 2: triggers at 10, 12, 14 replayed in order
        do_reset();
        while (cyc < 50) begin
            if (cyc == 13) check("t2_pend13", pending_count, 1);
            if (cyc == 15) check("t2_pend15", pending_count, 2);
            if (cyc == 22) check("t2_pulse22", pulse_out, 0);
            if (cyc == 23) check("t2_pulse23", pulse_out, 1);
            if (cyc == 23) check("t2_pend23", pending_count, 1);
            if (cyc == 34) check("t2_pend34", pending_count, 1);
            if (cyc == 35) check("t2_pend35", pending_count, 0);
            if (cyc == 35) check("t2_pulse35", pulse_out, 1);
            if (cyc == 42) check("t2_pulse42", pulse_out, 1);
            if (cyc == 43) check("t2_pulse43", pulse_out, 0);
            if (cyc == 46) check("t2_busy46", busy, 1);
            if (cyc == 47) check("t2_busy47", busy, 0);
            trigger = (cyc == 10) || (cyc == 12) || (cyc == 14);
            next_cycle();
        end

        // 3: saturation, one drop, four pulses total
        do_reset();
        rises  = 0;
        drops  = 0;
        prev_p = 1'b0;
        while (cyc < 70) begin
            if (pulse_out && !prev_p) rises++;
            if (dropped) drops++;
            prev_p = pulse_out;
            if (cyc == 15) check("t3_pend15", pending_count, 3);
            if (cyc == 16) check("t3_drop16", dropped, 1);
            if (cyc == 16) check("t3_pend16", pending_count, 3);
            trigger = (cyc == 10) || ((cyc >= 12) && (cyc <= 15));
            next_cycle();
        end
        check("t3_rises", rises, 4);
        check("t3_drops", drops, 1);
        check("t3_idle", busy, 0);

        // 4: full queue plus trigger on the OFF-expiry cycle
        do_reset();
        while (cyc < 26) begin
            if (cyc == 22) check("t4_pend22", pending_count, 3);
            if (cyc == 22) check("t4_pulse22", pulse_out, 0);
            if (cyc == 23) check("t4_pend23", pending_count, 3);
            if (cyc == 23) check("t4_drop23", dropped, 0);
            if (cyc == 23) check("t4_pulse23", pulse_out, 1);
            trigger = (cyc == 10) || ((cyc >= 12) && (cyc <= 14)) || (cyc == 22);
            next_cycle();
        end

        // 5: asynchronous reset mid-ON with two queued events
        do_reset();
        while (cyc < 16) begin
            trigger = (cyc == 10) || (cyc == 12) || (cyc == 14);
            next_cycle();
        end
        trigger = 1'b0;
        check("t5_pre_pend", pending_count, 2);
        check("t5_pre_pulse", pulse_out, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_pulse", pulse_out, 0);
        check("t5_async_busy", busy, 0);
        check("t5_async_pend", pending_count, 0);
        check("t5_async_drop", dropped, 0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            if (pulse_out || busy) rises++;
            next_cycle();
        end
        check("t5_residual", rises, 0);

        // 6: trigger on OFF expiry with empty queue re-enters ON directly
        do_reset();
        while (cyc < 36) begin
            if (cyc == 22) check("t6_busy22", busy, 1);
            if (cyc == 22) check("t6_pulse22", pulse_out, 0);
            if (cyc == 23) check("t6_pulse23", pulse_out, 1);
            if (cyc == 23) check("t6_busy23", busy, 1);
            if (cyc == 23) check("t6_pend23", pending_count, 0);
            if (cyc == 23) check("t6_drop23", dropped, 0);
            if (cyc == 30) check("t6_pulse30", pulse_out, 1);
            if (cyc == 31) check("t6_pulse31", pulse_out, 0);
            if (cyc == 35) check("t6_busy35", busy, 0);
            trigger = (cyc == 10) || (cyc == 22);
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
